shift_sequencer: RTL and testbench

Multi-cycle controller that sequences the team's 1-bit shift/rotate stage to perform N-position shifts and rotates of a 16-bit word, one position per clock. It sits between an operation issuer (start/busy/done handshake) and the single-step shift datapath. It latches operand, operation and fill bits, then iterates the step the requested number of times. It sequences shl, shr, rol and ror with the same semantics as the 1-bit stage.

---
 rtl/shift_sequencer_if.sv | 32 +++
 rtl/shift_sequencer.sv | 106 ++++++++++
 tb/tb_shift_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : shift_sequencer_if
// Description : Issuer-side handshake and operand bus of the shift sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface shift_sequencer_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
);
    logic             start;
    logic [1:0]       op;
    logic [CNT_W-1:0] amount;
    logic             fill_msb;
    logic             fill_lsb;
    logic [WIDTH-1:0] din;
    logic             abort;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dout;

    modport master (
        output start, op, amount, fill_msb, fill_lsb, din, abort,
        input  busy, done, dout
    );

    modport slave (
        input  start, op, amount, fill_msb, fill_lsb, din, abort,
        output busy, done, dout
    );
endinterface
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : shift_sequencer
// Description : Iterates a 1-bit shift/rotate step N times on a latched word.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    shift_sequencer_if.slave   bus
);
    localparam logic [1:0] c_OP_SHL = 2'd0;
    localparam logic [1:0] c_OP_SHR = 2'd1;
    localparam logic [1:0] c_OP_ROL = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_dout;
    logic [WIDTH-1:0] w_step;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_op;
    logic             r_fill_msb;
    logic             r_fill_lsb;
    logic             w_accept;

    // A new request is taken in IDLE and also in the DONE cycle (back-to-back).
    assign w_accept = bus.start && (r_state != S_SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_state_nxt = (bus.amount == '0) ? S_DONE : S_SHIFT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_step = r_dout;
        case (r_op)
            c_OP_SHL: w_step = {r_dout[WIDTH-2:0], r_fill_lsb};
            c_OP_SHR: w_step = {r_fill_msb, r_dout[WIDTH-1:1]};
            c_OP_ROL: w_step = {r_dout[WIDTH-2:0], r_dout[WIDTH-1]};
            default:  w_step = {r_dout[0], r_dout[WIDTH-1:1]};
        endcase
    end

    // An aborted operation keeps its partial result; only the count is cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout     <= '0;
            r_cnt      <= '0;
            r_op       <= '0;
            r_fill_msb <= 1'b0;
            r_fill_lsb <= 1'b0;
        end else if (w_accept) begin
            r_dout     <= bus.din;
            r_cnt      <= bus.amount;
            r_op       <= bus.op;
            r_fill_msb <= bus.fill_msb;
            r_fill_lsb <= bus.fill_lsb;
        end else if (r_state == S_SHIFT) begin
            if (bus.abort) begin
                r_cnt <= '0;
            end else begin
                r_dout <= w_step;
                r_cnt  <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign bus.busy = (r_state == S_SHIFT);
    assign bus.done = (r_state == S_DONE);
    assign bus.dout = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_sequencer
// Description : Directed and randomized checks of shift_sequencer timing/results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;
    localparam int WIDTH = 16;
    localparam int CNT_W = 4;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic [15:0] r_last;

    shift_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) sif ();

    shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result of an N-position operation written directly as word arithmetic.
    function automatic logic [15:0] model(input logic [1:0] o, input int n,
                                          input logic fm, input logic fl,
                                          input logic [15:0] d);
        logic [31:0] x, ones, r;
        x    = {16'h0000, d};
        ones = (32'd1 << n) - 32'd1;
        case (o)
            2'd0:    r = (x << n) | (fl ? ones : 32'd0);
            2'd1:    r = (x >> n) | (fm ? (ones << (16 - n)) : 32'd0);
            2'd2:    r = (x << n) | (x >> (16 - n));
            default: r = (x >> n) | (x << (16 - n));
        endcase
        return r[15:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic scramble();
        sif.op       = 2'($urandom_range(0, 3));
        sif.amount   = CNT_W'($urandom_range(0, 15));
        sif.fill_msb = 1'($urandom_range(0, 1));
        sif.fill_lsb = 1'($urandom_range(0, 1));
        sif.din      = 16'($urandom_range(0, 65535));
    endtask

    // Called at a negedge with the DUT in IDLE or DONE; returns at the negedge
    // inside the done cycle. poke_k>0 raises a stray start in that busy cycle.
    task automatic run_op(input logic [1:0] o, input int amt, input logic fm,
                          input logic fl, input logic [15:0] d, input int poke_k,
                          input string tag);
        logic [15:0] exp;
        exp          = model(o, amt, fm, fl, d);
        sif.start    = 1'b1;
        sif.op       = o;
        sif.amount   = CNT_W'(amt);
        sif.fill_msb = fm;
        sif.fill_lsb = fl;
        sif.din      = d;
        sif.abort    = 1'($urandom_range(0, 1));
        for (int k = 1; k <= amt + 1; k++) begin
            @(negedge clk);
            sif.start = 1'b0;
            sif.abort = 1'b0;
            scramble();
            check({tag, " busy"}, {31'd0, sif.busy}, {31'd0, (k <= amt)});
            check({tag, " done"}, {31'd0, sif.done}, {31'd0, (k == amt + 1)});
            if (k == poke_k && k <= amt) begin
                sif.start = 1'b1;
                sif.din   = ~d;
            end
        end
        check({tag, " dout"}, {16'd0, sif.dout}, {16'd0, exp});
        r_last = exp;
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check({tag, " idle busy"}, {31'd0, sif.busy}, 32'd0);
            check({tag, " idle done"}, {31'd0, sif.done}, 32'd0);
            check({tag, " idle dout"}, {16'd0, sif.dout}, {16'd0, r_last});
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        r_last = 16'h0000;
        rst    = 1'b1;
        sif.start = 1'b0;
        sif.abort = 1'b0;
        sif.op = 2'd0; sif.amount = '0; sif.fill_msb = 1'b0; sif.fill_lsb = 1'b0;
        sif.din = 16'h0000;

        repeat (2) @(negedge clk);
        check("reset busy", {31'd0, sif.busy}, 32'd0);
        check("reset done", {31'd0, sif.done}, 32'd0);
        check("reset dout", {16'd0, sif.dout}, 32'd0);
        rst = 1'b0;
        idle(1, "post reset");

        run_op(2'd0, 3, 1'b0, 1'b1, 16'h8001, 0, "shl3");
        check("shl3 const", {16'd0, sif.dout}, 32'h000F);
        idle(1, "shl3");

        run_op(2'd1, 15, 1'b1, 1'b0, 16'h8000, 0, "shr15");
        check("shr15 const", {16'd0, sif.dout}, 32'hFFFF);
        idle(1, "shr15");

        run_op(2'd3, 4, 1'b0, 1'b0, 16'h0001, 0, "ror4");
        check("ror4 const", {16'd0, sif.dout}, 32'h1000);
        idle(1, "ror4");

        run_op(2'd2, 1, 1'b0, 1'b0, 16'h8001, 0, "rol1");
        check("rol1 const", {16'd0, sif.dout}, 32'h0003);
        run_op(2'd2, 2, 1'b0, 1'b0, 16'h00F0, 0, "rol2 b2b");
        check("rol2 b2b const", {16'd0, sif.dout}, 32'h03C0);
        idle(1, "rol2 b2b");

        run_op(2'd2, 0, 1'b0, 1'b0, 16'h1234, 0, "rol0");
        check("rol0 const", {16'd0, sif.dout}, 32'h1234);
        idle(2, "rol0");

        run_op(2'd0, 5, 1'b0, 1'b1, 16'h0F0F, 2, "start in busy");
        idle(3, "start in busy");

        // Abort after two of five steps: the partial word stays, no done.
        sif.start = 1'b1; sif.op = 2'd0; sif.amount = CNT_W'(5);
        sif.fill_lsb = 1'b0; sif.fill_msb = 1'b1; sif.din = 16'h0001;
        @(negedge clk);
        sif.start = 1'b0;
        scramble();
        @(negedge clk);
        @(negedge clk);
        check("abort partial", {16'd0, sif.dout}, 32'h0004);
        sif.abort = 1'b1;
        @(negedge clk);
        sif.abort = 1'b0;
        r_last = 16'h0004;
        check("abort busy", {31'd0, sif.busy}, 32'd0);
        check("abort done", {31'd0, sif.done}, 32'd0);
        check("abort dout", {16'd0, sif.dout}, 32'h0004);
        idle(6, "after abort");

        // Asynchronous reset in the middle of a 10-step operation.
        sif.start = 1'b1; sif.op = 2'd1; sif.amount = CNT_W'(10);
        sif.fill_msb = 1'b1; sif.din = 16'hA5A5;
        @(negedge clk);
        sif.start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre reset busy", {31'd0, sif.busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async reset busy", {31'd0, sif.busy}, 32'd0);
        check("async reset done", {31'd0, sif.done}, 32'd0);
        check("async reset dout", {16'd0, sif.dout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        r_last = 16'h0000;
        idle(12, "after reset");

        for (int t = 0; t < 25; t++) begin
            int amt;
            amt = $urandom_range(0, 15);
            run_op(2'($urandom_range(0, 3)), amt, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
                   $urandom_range(0, amt), "random");
            if ($urandom_range(0, 1) == 1) begin
                idle($urandom_range(1, 2), "random");
            end
        end
        idle(2, "final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
